spw_mux_ch_status_pio_in: RTL and testbench

Avalon-MM slave input PIO that reads the SpaceWire mux per-channel status lines back into the Nios II address space. It is the read-side counterpart of the channel-select output PIOs. It synchronises asynchronous `in_port` lines into `clk`, exposes their level, and latches selected edges into a sticky edge-capture register. It can raise a maskable, level-sensitive interrupt to the CPU.

---
 rtl/spw_mux_ch_status_pio_in.sv | 110 +++++++++++
 tb/tb_spw_mux_ch_status_pio_in.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spw_mux_ch_status_pio_in.sv
// Avalon-MM input PIO returning the SpaceWire mux channel status lines, with sticky edge capture.
// Define SPW_PIO_IN_IRQ_EN to build the IRQMASK register and the level-sensitive irq output.
module spw_mux_ch_status_pio_in #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   logic [WIDTH-1:0] r_sync [SYNC_STAGES];
   logic [WIDTH-1:0] r_syncD;
   logic [WIDTH-1:0] r_edgeCap;
   logic [31:0]      r_readdata;

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_syncNext;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_capNext;
   logic [WIDTH-1:0] w_maskNext;
   logic [31:0]      w_rdMux;
   logic             w_wrEn;
   logic             w_unused;

   assign w_sync     = r_sync[SYNC_STAGES-1];
   assign w_syncNext = r_sync[SYNC_STAGES-2];
   assign w_wrEn     = chipselect & ~write_n;
   assign w_unused   = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_syncD <= '0;
      end else begin
         r_sync[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_syncD <= w_sync;
      end
   end

   generate
      if (EDGE_TYPE == 0) begin : g_rise
         assign w_edge = w_sync & ~r_syncD;
      end else if (EDGE_TYPE == 1) begin : g_fall
         assign w_edge = ~w_sync & r_syncD;
      end else begin : g_any
         assign w_edge = w_sync ^ r_syncD;
      end
   endgenerate

   // A coincident clear cannot hide a fresh edge: the edge term is ORed in after masking.
   assign w_clr     = (w_wrEn && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
   assign w_capNext = w_edge | (r_edgeCap & ~w_clr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_edgeCap <= '0;
      else          r_edgeCap <= w_capNext;
   end

`ifdef SPW_PIO_IN_IRQ_EN
   logic [WIDTH-1:0] r_irqMask;
   logic             r_irq;

   assign w_maskNext = (w_wrEn && address == 2'd2) ? writedata[WIDTH-1:0] : r_irqMask;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irqMask <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_irqMask <= w_maskNext;
         r_irq     <= |(r_edgeCap & r_irqMask);
      end
   end

   assign irq = r_irq;
`else
   assign w_maskNext = '0;
   assign irq        = 1'b0;
`endif

   // Reads return the state each register holds after this edge, so a level is readable
   // on the same edge it reaches the synchroniser output.
   always_comb begin
      w_rdMux = '0;
      case (address)
         2'd0:    w_rdMux[WIDTH-1:0] = w_syncNext;
         2'd2:    w_rdMux[WIDTH-1:0] = w_maskNext;
         2'd3:    w_rdMux[WIDTH-1:0] = w_capNext;
         default: w_rdMux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_readdata <= '0;
      else          r_readdata <= w_rdMux;
   end

   assign readdata = r_readdata;

endmodule

// File: tb/tb_spw_mux_ch_status_pio_in.sv
// Self-checking bench for spw_mux_ch_status_pio_in: cycle model from the register rules plus literal pins.
// Expectations follow SPW_PIO_IN_IRQ_EN when it is defined for the build.
module tb_spw_mux_ch_status_pio_in;

   localparam int W  = 8;
   localparam int N  = 2;
   localparam int ET = 0;
`ifdef SPW_PIO_IN_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic [1:0]    address    = 2'd0;
   logic          chipselect = 1'b0;
   logic          write_n    = 1'b1;
   logic [31:0]   writedata  = '0;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port    = '0;
   logic          irq;

   int total = 0;
   int bad   = 0;

   spw_mux_ch_status_pio_in #(.WIDTH(W), .SYNC_STAGES(N), .EDGE_TYPE(ET)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   // Model: the line level visible after edge k is the in_port sample taken N-1 edges earlier.
   logic [W-1:0] inHist[$];
   logic [W-1:0] mCap  = '0;
   logic [W-1:0] mMask = '0;
   logic         mIrq  = 1'b0;
   logic [31:0]  mRd   = '0;

   function automatic logic [W-1:0] syncAfter(int cnt);
      if (cnt >= N) return inHist[cnt-N];
      return '0;
   endfunction

   function automatic logic [W-1:0] edgeOf(logic [W-1:0] cur, logic [W-1:0] prev);
      if (ET == 0) return cur & ~prev;
      if (ET == 1) return ~cur & prev;
      return cur ^ prev;
   endfunction

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         inHist.delete();
         mCap = '0; mMask = '0; mIrq = 1'b0; mRd = '0;
      end else begin
         int           k;
         logic         wr;
         logic [W-1:0] edges, clr, nCap, nMask;
         logic [31:0]  nRd;
         k     = inHist.size();
         wr    = chipselect && !write_n;
         edges = edgeOf(syncAfter(k), syncAfter(k-1));
         clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
         nCap  = edges | (mCap & ~clr);
         nMask = (IRQ_ON && wr && address == 2'd2) ? writedata[W-1:0] : mMask;
         mIrq  = IRQ_ON && ((mCap & mMask) != '0);
         inHist.push_back(in_port);
         nRd = '0;
         case (address)
            2'd0: nRd[W-1:0] = syncAfter(k+1);
            2'd2: nRd[W-1:0] = nMask;
            2'd3: nRd[W-1:0] = nCap;
            default: nRd = '0;
         endcase
         mCap = nCap; mMask = nMask; mRd = nRd;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outputs are registered on posedge, so the negedge sees them settled.
   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         checkOutput("model_readdata", readdata, mRd);
         checkOutput("model_irq", {31'b0, irq}, {31'b0, mIrq});
      end
   end

   // Drive one bus cycle's inputs, let one active edge pass, return at the next negedge.
   task automatic applyStimulus(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                                input logic [W-1:0] inp);
      address    = a;
      chipselect = 1'b1;
      write_n    = ~wr;
      writedata  = wd;
      in_port    = inp;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      in_port = 8'hFF;
      repeat (3) @(negedge clk);
      checkOutput("rst_hold_readdata", readdata, 32'h0);
      checkOutput("rst_hold_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;

      // Line already high at release shows up as a rising capture at edge 3.
      applyStimulus(2'd0, 1'b0, 32'h0, 8'hFF);
      checkOutput("rst_data_e1", readdata, 32'h0);
      checkOutput("rst_irq_e1", {31'b0, irq}, 32'h0);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      checkOutput("rst_edgecap_e2", readdata, 32'h0);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      checkOutput("rst_edgecap_e3", readdata, 32'hFF);
      applyStimulus(2'd2, 1'b0, 32'h0, 8'hFF);
      checkOutput("rst_irqmask", readdata, 32'h0);

      applyStimulus(2'd3, 1'b1, 32'hFF, 8'h00);
      repeat (4) applyStimulus(2'd0, 1'b0, 32'h0, 8'h00);

      applyStimulus(2'd0, 1'b0, 32'h0, 8'h5A);
      checkOutput("level_e1", readdata, 32'h0);
      applyStimulus(2'd0, 1'b0, 32'h0, 8'h5A);
      checkOutput("level_e2", readdata, 32'h5A);
      repeat (4) applyStimulus(2'd0, 1'b0, 32'h0, 8'h00);
      applyStimulus(2'd3, 1'b1, 32'hFF, 8'h00);

      applyStimulus(2'd2, 1'b1, 32'h4, 8'h00);
      checkOutput("mask_wr_04", readdata, IRQ_ON ? 32'h4 : 32'h0);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h04);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h04);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h04);
      checkOutput("cap_rise_e3", readdata, 32'h4);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h04);
      checkOutput("irq_rise_e4", {31'b0, irq}, {31'b0, IRQ_ON});
      repeat (4) applyStimulus(2'd3, 1'b0, 32'h0, 8'h00);
      checkOutput("cap_fall_kept", readdata, 32'h4);
      applyStimulus(2'd3, 1'b1, 32'h4, 8'h00);
      checkOutput("cap_clr", readdata, 32'h0);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h00);
      checkOutput("irq_clr", {31'b0, irq}, 32'h0);

      applyStimulus(2'd3, 1'b0, 32'h0, 8'h01);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h01);
      applyStimulus(2'd3, 1'b1, 32'h1, 8'h01);
      checkOutput("edge_beats_clr", readdata, 32'h1);

      repeat (4) applyStimulus(2'd3, 1'b0, 32'h0, 8'h03);
      checkOutput("cap_03", readdata, 32'h3);
      checkOutput("irq_mask04", {31'b0, irq}, 32'h0);
      applyStimulus(2'd2, 1'b1, 32'h2, 8'h03);
      checkOutput("irq_mask02_same_edge", {31'b0, irq}, 32'h0);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h03);
      checkOutput("irq_mask02", {31'b0, irq}, {31'b0, IRQ_ON});
      applyStimulus(2'd2, 1'b1, 32'h0, 8'h03);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'h03);
      checkOutput("irq_mask00", {31'b0, irq}, 32'h0);

      applyStimulus(2'd2, 1'b1, 32'hFF, 8'h03);
      applyStimulus(2'd2, 1'b0, 32'h0, 8'h03);
      checkOutput("mask_ff_read", readdata, IRQ_ON ? 32'hFF : 32'h0);
      checkOutput("irq_mask_ff", {31'b0, irq}, {31'b0, IRQ_ON});
      repeat (4) applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      checkOutput("cap_poll_ff", readdata, 32'hFF);

      applyStimulus(2'd1, 1'b1, 32'hFFFF_FFFF, 8'hFF);
      checkOutput("reserved", readdata, 32'h0);

      // Asynchronous reset in the middle of a cycle.
      #2 reset_n = 1'b0;
      #1;
      checkOutput("midrst_readdata", readdata, 32'h0);
      checkOutput("midrst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      applyStimulus(2'd3, 1'b0, 32'h0, 8'hFF);
      checkOutput("midrst_cap_e3", readdata, 32'hFF);
      repeat (3) applyStimulus(2'd0, 1'b0, 32'h0, 8'hA5);

      chipselect = 1'b0;
      write_n    = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
